// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched
// Purpose  : Shares one ALU between two requesters. Requests are taken over
//            valid/ready handshakes with round-robin priority, issued to the
//            ALU one at a time, and the result is returned with the
//            requester ID over a valid/ready response channel.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready[1:0]      - per-port request handshake
//            req_sel*/req_op*/req_a*/req_b* - per-port request payload
//            rsp_valid/rsp_ready/rsp_id/rsp_data - response channel
//            alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op,
//            alu_a, alu_b (to ALU), alu_c (from ALU)
//            busy - high whenever the scheduler is not idle
// Revision : 1.0 - initial release
// ============================================================================
module alu_sched #(
    parameter int DW  = 8,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic          req_sel0,
    input  logic          req_sel1,
    input  logic [1:0]    req_op0,
    input  logic [1:0]    req_op1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          alu_en,
    output logic          alu_a_en,
    output logic          alu_b_en,
    output logic [1:0]    alu_a_op,
    output logic [1:0]    alu_b_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_c,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Wait counter preload: WAIT lasts LAT cycles, ending when the count hits 0.
    localparam logic [3:0] c_cnt_init = 4'(LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_ptr;
    logic          r_g;
    logic          r_sel;
    logic [1:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [3:0]    r_cnt;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_data;

    logic          w_gnt;
    logic          w_accept;
    logic          w_drive;

    // Lone requester wins outright; on a tie the priority pointer decides.
    always_comb begin
        w_gnt = r_ptr;
        unique case (req_valid)
            2'b01:   w_gnt = 1'b0;
            2'b10:   w_gnt = 1'b1;
            default: w_gnt = r_ptr;
        endcase
    end

    // Ready is held low while reset is asserted so the handshake cannot
    // appear to complete against registers that are being cleared.
    assign w_accept = (r_state == S_IDLE) && !rst && req_valid[w_gnt];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next    = r_state;
        w_drive   = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        alu_en    = 1'b0;
        alu_a_en  = 1'b0;
        alu_b_en  = 1'b0;
        alu_a_op  = 2'b00;
        alu_b_op  = 2'b00;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready = w_gnt ? 2'b10 : 2'b01;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_drive = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                w_drive = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // ALU controls stay asserted for the whole ISSUE+WAIT window.
        if (w_drive) begin
            alu_en   = 1'b1;
            alu_a_en = ~r_sel;
            alu_b_en = r_sel;
            alu_a_op = r_sel ? 2'b00 : r_op;
            alu_b_op = r_sel ? r_op  : 2'b00;
        end
    end

    // Operand buses come straight from the captured payload, so they keep
    // their last value between operations.
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign rsp_id   = r_rsp_id;
    assign rsp_data = r_rsp_data;

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 1'b0;
            r_g        <= 1'b0;
            r_sel      <= 1'b0;
            r_op       <= 2'b00;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= 4'd0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_g   <= w_gnt;
                r_sel <= w_gnt ? req_sel1 : req_sel0;
                r_op  <= w_gnt ? req_op1  : req_op0;
                r_a   <= w_gnt ? req_a1   : req_a0;
                r_b   <= w_gnt ? req_b1   : req_b0;
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= c_cnt_init;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Only the last WAIT cycle's ALU result is taken.
            if ((r_state == S_WAIT) && (r_cnt == 4'd0)) begin
                r_rsp_data <= alu_c;
                r_rsp_id   <= r_g;
            end

            // Priority moves only on a completed response, never on grant.
            if ((r_state == S_RESP) && rsp_ready) begin
                r_ptr <= ~r_g;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sched
// Purpose  : Directed self-checking bench for alu_sched. Instance u1 (LAT=1)
//            is paired with a behavioural ALU; instance u4 (LAT=4) has its
//            ALU result driven cycle by cycle from the stimulus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- LAT=1 instance ----------------
    logic [1:0] rq_valid1 = '0;
    logic [1:0] rr1;
    logic       sel0_1 = 0, sel1_1 = 0;
    logic [1:0] op0_1 = 0, op1_1 = 0;
    logic [7:0] a0_1 = 0, b0_1 = 0, a1_1 = 0, b1_1 = 0;
    logic       rsp_valid1, rsp_id1;
    logic       rsp_ready1 = 1'b0;
    logic [7:0] rsp_data1;
    logic       alu_en1, alu_a_en1, alu_b_en1;
    logic [1:0] alu_a_op1, alu_b_op1;
    logic [7:0] alu_a1, alu_b1, alu_c1;
    logic       busy1;

    alu_sched #(.DW(8), .LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(rq_valid1), .req_ready(rr1),
        .req_sel0(sel0_1), .req_sel1(sel1_1),
        .req_op0(op0_1), .req_op1(op1_1),
        .req_a0(a0_1), .req_b0(b0_1), .req_a1(a1_1), .req_b1(b1_1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_id(rsp_id1), .rsp_data(rsp_data1),
        .alu_en(alu_en1), .alu_a_en(alu_a_en1), .alu_b_en(alu_b_en1),
        .alu_a_op(alu_a_op1), .alu_b_op(alu_b_op1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1),
        .busy(busy1)
    );

    // Behavioural ALU: group A = AND/NAND/OR/XOR, group B = XNOR/AND/NOR/OR
    always_comb begin
        alu_c1 = 8'h00;
        if (alu_a_en1) begin
            case (alu_a_op1)
                2'b00:   alu_c1 = alu_a1 & alu_b1;
                2'b01:   alu_c1 = ~(alu_a1 & alu_b1);
                2'b10:   alu_c1 = alu_a1 | alu_b1;
                default: alu_c1 = alu_a1 ^ alu_b1;
            endcase
        end else if (alu_b_en1) begin
            case (alu_b_op1)
                2'b00:   alu_c1 = ~(alu_a1 ^ alu_b1);
                2'b01:   alu_c1 = alu_a1 & alu_b1;
                2'b10:   alu_c1 = ~(alu_a1 | alu_b1);
                default: alu_c1 = alu_a1 | alu_b1;
            endcase
        end
    end

    // ---------------- LAT=4 instance ----------------
    logic [1:0] rq_valid4 = '0;
    logic [1:0] rr4;
    logic       sel0_4 = 0, sel1_4 = 0;
    logic [1:0] op0_4 = 0, op1_4 = 0;
    logic [7:0] a0_4 = 0, b0_4 = 0, a1_4 = 0, b1_4 = 0;
    logic       rsp_valid4, rsp_id4;
    logic       rsp_ready4 = 1'b1;
    logic [7:0] rsp_data4;
    logic       alu_en4, alu_a_en4, alu_b_en4;
    logic [1:0] alu_a_op4, alu_b_op4;
    logic [7:0] alu_a4, alu_b4;
    logic [7:0] alu_c4 = 8'h00;
    logic       busy4;

    alu_sched #(.DW(8), .LAT(4)) u4 (
        .clk(clk), .rst(rst),
        .req_valid(rq_valid4), .req_ready(rr4),
        .req_sel0(sel0_4), .req_sel1(sel1_4),
        .req_op0(op0_4), .req_op1(op1_4),
        .req_a0(a0_4), .req_b0(b0_4), .req_a1(a1_4), .req_b1(b1_4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_id(rsp_id4), .rsp_data(rsp_data4),
        .alu_en(alu_en4), .alu_a_en(alu_a_en4), .alu_b_en(alu_b_en4),
        .alu_a_op(alu_a_op4), .alu_b_op(alu_b_op4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_c(alu_c4),
        .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------- reset values ----------
        mid;
        chk("rst_req_ready", rr1, 2'b00);
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_rsp_id", rsp_id1, 0);
        chk("rst_rsp_data", rsp_data1, 0);
        chk("rst_alu_en", alu_en1, 0);
        chk("rst_alu_a_en", alu_a_en1, 0);
        chk("rst_alu_b_en", alu_b_en1, 0);
        chk("rst_alu_ops", {alu_a_op1, alu_b_op1}, 0);
        chk("rst_alu_ab", {alu_a1, alu_b1}, 0);
        chk("rst_busy", busy1, 0);
        next_cycle;
        rst = 1'b0;

        // ---------- group-A AND on port 0 ----------
        rq_valid1 = 2'b01; sel0_1 = 0; op0_1 = 2'b00; a0_1 = 8'hF0; b0_1 = 8'h3C;
        rsp_ready1 = 1'b1;
        mid;
        chk("t1_req_ready", rr1, 2'b01);
        chk("t1_idle_busy", busy1, 0);
        next_cycle;
        rq_valid1 = 2'b00;
        mid;                                    // ISSUE
        chk("t1_issue_en", alu_en1, 1);
        chk("t1_issue_a_en", alu_a_en1, 1);
        chk("t1_issue_b_en", alu_b_en1, 0);
        chk("t1_issue_a_op", alu_a_op1, 2'b00);
        chk("t1_issue_alu_a", alu_a1, 8'hF0);
        chk("t1_issue_alu_b", alu_b1, 8'h3C);
        chk("t1_issue_ready", rr1, 2'b00);
        chk("t1_issue_busy", busy1, 1);
        next_cycle;
        mid;                                    // WAIT
        chk("t1_wait_en", alu_en1, 1);
        chk("t1_wait_a_en", alu_a_en1, 1);
        chk("t1_wait_rsp_valid", rsp_valid1, 0);
        next_cycle;
        mid;                                    // RESP
        chk("t1_rsp_valid", rsp_valid1, 1);
        chk("t1_rsp_data", rsp_data1, 8'h30);
        chk("t1_rsp_id", rsp_id1, 0);
        chk("t1_resp_alu_en", alu_en1, 0);
        next_cycle;
        mid;
        chk("t1_after_rsp_valid", rsp_valid1, 0);
        chk("t1_after_busy", busy1, 0);

        // ---------- group-B NOR on port 1 ----------
        next_cycle;
        rq_valid1 = 2'b10; sel1_1 = 1; op1_1 = 2'b10; a1_1 = 8'h0F; b1_1 = 8'hA0;
        mid;
        chk("t2_req_ready", rr1, 2'b10);
        next_cycle;
        rq_valid1 = 2'b00;
        mid;
        chk("t2_alu_a_en", alu_a_en1, 0);
        chk("t2_alu_b_en", alu_b_en1, 1);
        chk("t2_alu_b_op", alu_b_op1, 2'b10);
        chk("t2_alu_a_op", alu_a_op1, 2'b00);
        next_cycle;
        next_cycle;
        mid;
        chk("t2_rsp_valid", rsp_valid1, 1);
        chk("t2_rsp_data", rsp_data1, 8'h50);
        chk("t2_rsp_id", rsp_id1, 1);

        // ---------- round robin, both ports valid ----------
        next_cycle;
        sel0_1 = 0; op0_1 = 2'b11; a0_1 = 8'h55; b0_1 = 8'h0F;   // XOR -> 5A
        sel1_1 = 1; op1_1 = 2'b01; a1_1 = 8'hCC; b1_1 = 8'hAA;   // AND -> 88
        rq_valid1 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            mid;
            chk("rr_grant", rr1, (i % 2) ? 2'b10 : 2'b01);
            next_cycle;
            mid;
            chk("rr_issue_no_ready", rr1, 2'b00);
            chk("rr_issue_busy", busy1, 1);
            next_cycle;
            mid;
            chk("rr_wait_no_ready", rr1, 2'b00);
            next_cycle;
            mid;
            chk("rr_rsp_valid", rsp_valid1, 1);
            chk("rr_rsp_id", rsp_id1, (i % 2));
            chk("rr_rsp_data", rsp_data1, (i % 2) ? 8'h88 : 8'h5A);
            chk("rr_resp_no_ready", rr1, 2'b00);
            next_cycle;
        end
        rq_valid1 = 2'b00;

        // ---------- response stall ----------
        rq_valid1 = 2'b01; rsp_ready1 = 1'b0;
        mid;
        chk("st_grant0", rr1, 2'b01);
        next_cycle;
        rq_valid1 = 2'b10;                      // port 1 waits behind the stall
        mid;
        chk("st_issue_no_ready", rr1, 2'b00);
        next_cycle;
        mid;
        chk("st_wait_no_ready", rr1, 2'b00);
        next_cycle;
        mid;
        chk("st_rsp_valid", rsp_valid1, 1);
        chk("st_rsp_data", rsp_data1, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            next_cycle;
            mid;
            chk("st_hold_valid", rsp_valid1, 1);
            chk("st_hold_data", rsp_data1, 8'h5A);
            chk("st_hold_id", rsp_id1, 0);
            chk("st_hold_no_ready", rr1, 2'b00);
        end
        rsp_ready1 = 1'b1;
        next_cycle;
        mid;
        chk("st_next_grant", rr1, 2'b10);
        chk("st_next_rsp_low", rsp_valid1, 0);
        next_cycle;
        rq_valid1 = 2'b00;
        next_cycle;
        next_cycle;
        mid;
        chk("st_p1_rsp_id", rsp_id1, 1);
        chk("st_p1_rsp_data", rsp_data1, 8'h88);
        next_cycle;

        // ---------- reset during WAIT ----------
        rq_valid1 = 2'b01;                      // port 0 alone moves ptr to 1
        mid;
        chk("rw_pre_grant0", rr1, 2'b01);
        next_cycle;
        rq_valid1 = 2'b00;
        next_cycle;
        next_cycle;
        mid;
        chk("rw_pre_rsp_id", rsp_id1, 0);
        next_cycle;
        rq_valid1 = 2'b11;
        mid;
        chk("rw_tie_ptr1", rr1, 2'b10);
        next_cycle;                             // ISSUE for port 1
        next_cycle;                             // WAIT
        rst = 1'b1;
        mid;
        chk("rw_busy", busy1, 0);
        chk("rw_alu_en", alu_en1, 0);
        chk("rw_alu_b_en", alu_b_en1, 0);
        chk("rw_alu_b_op", alu_b_op1, 2'b00);
        chk("rw_alu_a", alu_a1, 8'h00);
        chk("rw_alu_b", alu_b1, 8'h00);
        chk("rw_rsp_valid", rsp_valid1, 0);
        chk("rw_rsp_data", rsp_data1, 8'h00);
        chk("rw_req_ready", rr1, 2'b00);
        next_cycle;
        rst = 1'b0;
        mid;
        chk("rw_after_rsp_valid", rsp_valid1, 0);
        chk("rw_after_grant0", rr1, 2'b01);
        next_cycle;
        rq_valid1 = 2'b00;
        next_cycle;
        next_cycle;
        mid;
        chk("rw_after_rsp_id", rsp_id1, 0);
        chk("rw_after_rsp_data", rsp_data1, 8'h5A);
        next_cycle;

        // ---------- LAT=4: only the last WAIT cycle is sampled ----------
        rq_valid4 = 2'b01; sel0_4 = 0; op0_4 = 2'b10; a0_4 = 8'h12; b0_4 = 8'h34;
        alu_c4 = 8'hEE;
        mid;                                    // T
        chk("l4_grant", rr4, 2'b01);
        next_cycle;
        rq_valid4 = 2'b00;
        alu_c4 = 8'h11;
        mid;                                    // T+1 ISSUE
        chk("l4_issue_en", alu_en4, 1);
        chk("l4_issue_a_op", alu_a_op4, 2'b10);
        chk("l4_issue_alu_a", alu_a4, 8'h12);
        for (int j = 0; j < 3; j++) begin       // T+2..T+4
            next_cycle;
            alu_c4 = 8'h22 + 8'(j * 17);
            mid;
            chk("l4_wait_no_rsp", rsp_valid4, 0);
            chk("l4_wait_en", alu_en4, 1);
        end
        next_cycle;                             // T+5 last WAIT
        alu_c4 = 8'hA5;
        mid;
        chk("l4_last_wait_no_rsp", rsp_valid4, 0);
        chk("l4_last_wait_en", alu_en4, 1);
        next_cycle;                             // T+6 RESP
        alu_c4 = 8'hFF;
        mid;
        chk("l4_rsp_valid", rsp_valid4, 1);
        chk("l4_rsp_data", rsp_data4, 8'hA5);
        chk("l4_rsp_id", rsp_id4, 0);
        chk("l4_resp_alu_en", alu_en4, 0);
        next_cycle;
        mid;
        chk("l4_after_rsp_valid", rsp_valid4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares a single ALU between two requesters. Requests are accepted over valid/ready handshakes, with round-robin priority. The scheduler drives the ALU enable, group-select and operand lines, waits the ALU's fixed result latency, and returns the result with the requester ID over a valid/ready response channel. One operation is in flight at a time. The block sits between the requester masters and the ALU datapath.

## Interface
Parameters:
- DW, 8, operand/result width
- LAT, 1, ALU result latency in cycles after the issue cycle (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port request accept
- req_sel0, req_sel1  in  1 each  op group: 0 = group A, 1 = group B
- req_op0, req_op1  in  2 each  op code. Group A: 00 AND, 01 NAND, 10 OR, 11 XOR. Group B: 00 XNOR, 01 AND, 10 NOR, 11 OR
- req_a0, req_b0, req_a1, req_b1  in  DW each  operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  port that issued the response
- rsp_data  out  DW  captured ALU result
- alu_en  out  1  ALU enable
- alu_a_en, alu_b_en  out  1 each  group A / group B enable
- alu_a_op, alu_b_op  out  2 each  group op codes
- alu_a, alu_b  out  DW each  operands to the ALU
- alu_c  in  DW  ALU result
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Priority pointer ptr resets to 0.
- IDLE arbitration:
  - If only one req_valid bit is set, that port is granted.
  - If both are set, port ptr is granted.
  - req_ready[g] = (state==IDLE) && req_valid[g] && granted; this is combinational. The other bit is 0.
  - On the handshake, sel/op/a/b/g are registered and the FSM moves to ISSUE.
- ISSUE lasts 1 cycle and drives the ALU:
  - alu_en=1
  - alu_a_en=~sel, alu_b_en=sel
  - alu_a_op = sel ? 0 : op; alu_b_op = sel ? op : 0
  - alu_a/alu_b = registered operands
  - The wait counter loads LAT-1. Next state is WAIT.
- WAIT:
  - All ALU outputs are held at their ISSUE values, including alu_en=1.
  - The counter decrements each cycle.
  - In the cycle the counter equals 0, alu_c is captured into rsp_data, rsp_id=g, and the next state is RESP.
- RESP:
  - alu_en, alu_a_en, alu_b_en and both ops are 0.
  - rsp_valid=1, with rsp_data and rsp_id stable until rsp_ready.
  - On rsp_valid && rsp_ready: ptr <= ~g, and the next state is IDLE.
- Outside ISSUE/WAIT:
  - alu_en, alu_a_en, alu_b_en and both op buses are 0.
  - alu_a/alu_b keep their last value.
- Requests are never accepted outside IDLE. Requesters hold req_valid and their payload stable until ready.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_en=0, alu_a_en=0, alu_b_en=0, alu_a_op=0, alu_b_op=0, alu_a=0, alu_b=0, busy=0.
- Handshake in cycle T:
  - T+1 is ISSUE.
  - T+2..T+1+LAT is WAIT.
  - alu_c is sampled at the end of cycle T+1+LAT.
  - rsp_valid rises in cycle T+2+LAT.
- With LAT=1, rsp_valid appears 3 cycles after acceptance.
- A new request can be accepted at the earliest in the cycle after the response handshake. Minimum issue interval is LAT+3 cycles when rsp_ready is held high.
- Round-robin fairness: with both ports continuously valid, grants alternate 0,1,0,1,...
- ptr updates only on a response handshake, never on a single-port grant alone. A lone port therefore may be granted back-to-back indefinitely.
- A req_valid deasserted before its grant is simply not served. No state is retained.
- rsp_ready low stalls in RESP indefinitely. No request is accepted during the stall.
- Asynchronous rst mid-operation (ISSUE/WAIT/RESP):
  - All registers return to their reset values immediately.
  - The in-flight operation and response are discarded.
  - After rst deasserts, the first arbitration uses ptr=0.

## Test plan
- Single group-A AND on port 0 (a=0xF0, b=0x3C, sel=0, op=00), LAT=1, rsp_ready=1, bench ALU model. Required:
  - req_ready[0] in cycle T
  - alu_en/alu_a_en=1 in T+1..T+2, alu_a_op=00
  - rsp_valid in T+3 with rsp_data=0x30, rsp_id=0
- Group-B NOR on port 1 (a=0x0F, b=0xA0, sel=1, op=10) -> alu_b_en=1, alu_a_en=0, alu_b_op=10, rsp_data=0x50, rsp_id=1.
- Both ports held valid for 6 operations after reset -> grant order 0,1,0,1,0,1. Each response's rsp_id matches its grant; never two requests in flight.
- rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable. req_ready=0 throughout, and the next grant occurs only after the handshake.
- LAT=4 build -> rsp_valid exactly 6 cycles after acceptance. alu_c is sampled only in the last WAIT cycle: the bench drives garbage earlier, and rsp_data must equal the final value.
- rst pulse during WAIT -> all outputs at reset values the same cycle, with no rsp_valid for the aborted op. The next simultaneous request pair grants port 0 first.
